// File: rtl/rc4_cipher_packer_if.sv
// Word-side and byte-side signal bundle for rc4_cipher_packer.
// slave = the packer, master = the RC4 core / consumer side driving it.
interface rc4_cipher_packer_if;
    logic [7:0]  din;
    logic        din_valid;
    logic        flush;
    logic [31:0] dout;
    logic [2:0]  dout_bytes;
    logic        dout_valid;
    logic        dout_ready;
    logic        almost_full;
    logic        overflow;
    logic        clear_overflow;

    modport slave (
        input  din, din_valid, flush, dout_ready, clear_overflow,
        output dout, dout_bytes, dout_valid, almost_full, overflow
    );

    modport master (
        output din, din_valid, flush, dout_ready, clear_overflow,
        input  dout, dout_bytes, dout_valid, almost_full, overflow
    );
endinterface

// File: rtl/rc4_cipher_packer.sv
// Packs the RC4 ciphertext byte stream into 32-bit words behind a show-ahead FIFO.
// Define CIPHER_PACKER_BIG_ENDIAN_EN for big-endian (left-aligned) packing.
module rc4_cipher_packer #(
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned AFULL_MARGIN = 2
) (
    input  logic                 clock,
    input  logic                 rst_n,
    rc4_cipher_packer_if.slave   bus
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_LVL  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] AFULL_LVL = (AW+1)'(FIFO_DEPTH - AFULL_MARGIN);

    logic [31:0]   pack_q, pack_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [31:0]   merged;
    logic [2:0]    merged_cnt;
    logic          push;
    logic          pop;
    logic          full;
    logic          push_ok;
    logic          drop;

    logic [34:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   occ_q, occ_d;
    logic [34:0]   head;
    logic [34:0]   last_q;
    logic          overflow_q;

    // The incoming byte is merged first, so a flush in the same cycle carries it.
    always_comb begin
        merged = pack_q;
        if (bus.din_valid) begin
`ifdef CIPHER_PACKER_BIG_ENDIAN_EN
            case (cnt_q)
                2'd0:    merged[31:24] = bus.din;
                2'd1:    merged[23:16] = bus.din;
                2'd2:    merged[15:8]  = bus.din;
                default: merged[7:0]   = bus.din;
            endcase
`else
            case (cnt_q)
                2'd0:    merged[7:0]   = bus.din;
                2'd1:    merged[15:8]  = bus.din;
                2'd2:    merged[23:16] = bus.din;
                default: merged[31:24] = bus.din;
            endcase
`endif
        end
        merged_cnt = {1'b0, cnt_q} + {2'b00, bus.din_valid};
        push       = (merged_cnt == 3'd4) || (bus.flush && (merged_cnt != 3'd0));
        if (push) begin
            pack_d = '0;
            cnt_d  = '0;
        end else begin
            pack_d = merged;
            cnt_d  = merged_cnt[1:0];
        end
    end

    assign head    = mem_q[rd_ptr_q];
    assign full    = (occ_q == FULL_LVL);
    assign pop     = (occ_q != '0) && bus.dout_ready;
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;

    always_comb begin
        occ_d = occ_q;
        case ({push_ok, pop})
            2'b10:   occ_d = occ_q + (AW+1)'(1);
            2'b01:   occ_d = occ_q - (AW+1)'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            pack_q     <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            last_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            pack_q <= pack_d;
            cnt_q  <= cnt_d;
            occ_q  <= occ_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                last_q   <= head;
            end
            if (drop)
                overflow_q <= 1'b1;
            else if (bus.clear_overflow)
                overflow_q <= 1'b0;
        end
    end

    // Storage needs no reset: entries are only visible while occupancy covers them.
    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= {merged_cnt, merged};
    end

    // When empty, the outputs hold the last popped entry (zero after reset).
    assign bus.dout_valid  = (occ_q != '0);
    assign bus.dout        = bus.dout_valid ? head[31:0]  : last_q[31:0];
    assign bus.dout_bytes  = bus.dout_valid ? head[34:32] : last_q[34:32];
    assign bus.almost_full = (occ_q >= AFULL_LVL);
    assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_rc4_cipher_packer.sv
// Directed self-checking bench for rc4_cipher_packer (FIFO_DEPTH=8, AFULL_MARGIN=2).
module tb_rc4_cipher_packer;
    logic clock;
    logic rst_n;
    int   checks;
    int   errors;

    rc4_cipher_packer_if bus ();

    rc4_cipher_packer #(.FIFO_DEPTH(8), .AFULL_MARGIN(2)) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected word from bytes in arrival order; unused bytes passed as 0.
    function automatic logic [31:0] word_of(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] b2, input logic [7:0] b3);
`ifdef CIPHER_PACKER_BIG_ENDIAN_EN
        return {b0, b1, b2, b3};
`else
        return {b3, b2, b1, b0};
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.din       = b;
        bus.din_valid = 1'b1;
        tick();
        bus.din_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        checks = 0;
        errors = 0;
        rst_n              = 1'b0;
        bus.din            = '0;
        bus.din_valid      = 1'b0;
        bus.flush          = 1'b0;
        bus.dout_ready     = 1'b0;
        bus.clear_overflow = 1'b0;
        #23 rst_n = 1'b1;
        tick();

        check("rst_dout",   bus.dout, 32'h0);
        check("rst_bytes",  32'(bus.dout_bytes), 32'd0);
        check("rst_valid",  32'(bus.dout_valid), 32'd0);
        check("rst_afull",  32'(bus.almost_full), 32'd0);
        check("rst_ovf",    32'(bus.overflow), 32'd0);

        // 1: full word, latency one cycle, visible for one cycle
        bus.dout_ready = 1'b1;
        send(8'h11); send(8'h22); send(8'h33);
        check("t1_novalid_early", 32'(bus.dout_valid), 32'd0);
        send(8'h44);
        check("t1_valid", 32'(bus.dout_valid), 32'd1);
        check("t1_dout",  bus.dout, word_of(8'h11, 8'h22, 8'h33, 8'h44));
        check("t1_bytes", 32'(bus.dout_bytes), 32'd4);
        tick();
        check("t1_valid_drop", 32'(bus.dout_valid), 32'd0);
        check("t1_hold", bus.dout, word_of(8'h11, 8'h22, 8'h33, 8'h44));

        // 2: partial flush, then flush with nothing pending
        send(8'hAA); send(8'hBB);
        bus.flush = 1'b1; tick(); bus.flush = 1'b0;
        check("t2_valid", 32'(bus.dout_valid), 32'd1);
        check("t2_dout",  bus.dout, word_of(8'hAA, 8'hBB, 8'h00, 8'h00));
        check("t2_bytes", 32'(bus.dout_bytes), 32'd2);
        tick();
        bus.flush = 1'b1; tick(); bus.flush = 1'b0;
        check("t2_empty_flush", 32'(bus.dout_valid), 32'd0);

        // 3: flush coincident with third byte
        send(8'h01); send(8'h02);
        bus.flush = 1'b1; send(8'h03); bus.flush = 1'b0;
        check("t3_valid", 32'(bus.dout_valid), 32'd1);
        check("t3_dout",  bus.dout, word_of(8'h01, 8'h02, 8'h03, 8'h00));
        check("t3_bytes", 32'(bus.dout_bytes), 32'd3);
        tick();
        check("t3_single", 32'(bus.dout_valid), 32'd0);

        // 4: fill with no consumer, almost_full, overflow, drain
        bus.dout_ready = 1'b0;
        for (int i = 0; i < 36; i++) begin
            send(8'(i));
            if (i == 19) check("t4_afull_5", 32'(bus.almost_full), 32'd0);
            if (i == 23) check("t4_afull_6", 32'(bus.almost_full), 32'd1);
            if (i == 31) check("t4_ovf_before", 32'(bus.overflow), 32'd0);
        end
        check("t4_ovf_set", 32'(bus.overflow), 32'd1);
        bus.dout_ready = 1'b1;
        for (int w = 0; w < 8; w++) begin
            check("t4_drain_valid", 32'(bus.dout_valid), 32'd1);
            check("t4_drain_word", bus.dout,
                  word_of(8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3)));
            tick();
        end
        check("t4_drained", 32'(bus.dout_valid), 32'd0);
        check("t4_ovf_sticky", 32'(bus.overflow), 32'd1);
        bus.clear_overflow = 1'b1; tick(); bus.clear_overflow = 1'b0;
        check("t4_ovf_clear", 32'(bus.overflow), 32'd0);

        // 5: full FIFO, pop and push in the same cycle
        bus.dout_ready = 1'b0;
        for (int i = 0; i < 32; i++) send(8'(8'h80 + i));
        check("t5_afull", 32'(bus.almost_full), 32'd1);
        send(8'hC0); send(8'hC1); send(8'hC2);
        check("t5_head", bus.dout, word_of(8'h80, 8'h81, 8'h82, 8'h83));
        bus.dout_ready = 1'b1;
        send(8'hC3);
        check("t5_no_ovf", 32'(bus.overflow), 32'd0);
        for (int w = 1; w < 8; w++) begin
            b = 8'(8'h80 + 4*w);
            check("t5_drain_word", bus.dout, word_of(b, b + 8'd1, b + 8'd2, b + 8'd3));
            tick();
        end
        check("t5_new_valid", 32'(bus.dout_valid), 32'd1);
        check("t5_new_word", bus.dout, word_of(8'hC0, 8'hC1, 8'hC2, 8'hC3));
        tick();
        check("t5_empty", 32'(bus.dout_valid), 32'd0);

        // 6: asynchronous reset mid-word with words queued
        bus.dout_ready = 1'b0;
        for (int i = 0; i < 14; i++) send(8'(8'h10 + i));
        check("t6_queued", 32'(bus.dout_valid), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("t6_rst_dout",  bus.dout, 32'h0);
        check("t6_rst_bytes", 32'(bus.dout_bytes), 32'd0);
        check("t6_rst_valid", 32'(bus.dout_valid), 32'd0);
        check("t6_rst_afull", 32'(bus.almost_full), 32'd0);
        check("t6_rst_ovf",   32'(bus.overflow), 32'd0);
        #2 rst_n = 1'b1;
        tick();
        bus.dout_ready = 1'b1;
        send(8'h55); send(8'h66); send(8'h77);
        check("t6_partial_gone", 32'(bus.dout_valid), 32'd0);
        send(8'h88);
        check("t6_valid", 32'(bus.dout_valid), 32'd1);
`ifdef CIPHER_PACKER_BIG_ENDIAN_EN
        check("t6_word", bus.dout, 32'h55667788);
`else
        check("t6_word", bus.dout, 32'h88776655);
`endif
        check("t6_bytes", 32'(bus.dout_bytes), 32'd4);
        tick();
        check("t6_single", 32'(bus.dout_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rc4_cipher_packer.md
Name: rc4_cipher_packer

Overview:
- Downstream stage of the RC4 encryption core. Consumes its byte stream (ciphertext, valid_dout) and packs bytes into 32-bit words.
- Buffers the packed words in a small FIFO and presents them on a valid/ready word interface to the bus/DMA side.
- The RC4 core has no output backpressure, so this block exports almost_full for the plaintext source to throttle valid_din. It also flags any word lost to overflow.

Parameters:
- FIFO_DEPTH, 8, number of 32-bit word entries; power of two, minimum 2.
- AFULL_MARGIN, 2, almost_full asserts when occupancy >= FIFO_DEPTH - AFULL_MARGIN; range 1..FIFO_DEPTH-1.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- din  in  8  cipher byte from RC4 core (ciphertext).
- din_valid  in  1  byte strobe (RC4 valid_dout); each high cycle is one new byte.
- flush  in  1  one-cycle request to emit a partially filled word.
- dout  out  32  packed word at FIFO head.
- dout_bytes  out  3  number of valid bytes in dout, 1..4.
- dout_valid  out  1  FIFO head valid.
- dout_ready  in  1  consumer accepts dout when high together with dout_valid.
- almost_full  out  1  throttle hint to plaintext source.
- overflow  out  1  sticky: a word was dropped.
- clear_overflow  in  1  clears overflow.

Behaviour:
- Reset values: dout=0, dout_bytes=0, dout_valid=0, almost_full=0, overflow=0, pack register=0, pack count=0, FIFO empty.
- Reset is accepted asynchronously at any time, including mid-word. A partial word and all FIFO contents are discarded.
- Packing, little-endian:
  - Byte k (k = pack count 0..3) is written to pack[8k+7:8k]; pack count increments mod 4.
  - When byte 3 is accepted, {din, pack[23:0]} is pushed that same cycle with bytes=4. The pack register and count then clear.
- Flush, when pack count > 0:
  - Pushes the pack register with bytes=count. Unused upper bytes are 0.
  - Pack register and count clear.
- Flush with a byte in the same cycle:
  - The byte is included first, then the result is pushed with bytes=count+1.
  - If that byte completes a word, exactly one push of 4 bytes occurs.
- Flush with pack count 0 and no byte: no-op, no empty word is pushed.
- FIFO:
  - Show-ahead. dout/dout_bytes reflect the head entry whenever dout_valid=1.
  - dout/dout_bytes are held stable while dout_valid=1 and dout_ready=0.
  - Pop occurs on dout_valid & dout_ready.
- Latency: a word completed in cycle N appears with dout_valid=1 in cycle N+1 when the FIFO was empty.
- Full FIFO: push and pop in the same cycle succeed and occupancy is unchanged.
- Overflow:
  - A push while full without a same-cycle pop drops the new word. FIFO contents are unchanged.
  - overflow is set the next cycle and stays set.
- clear_overflow clears overflow; a same-cycle drop takes priority (overflow stays 1).
- almost_full is decoded from the registered occupancy and updates the cycle after the occupancy changes.
- Pointer arithmetic: read and write pointers wrap mod FIFO_DEPTH. Occupancy uses log2(FIFO_DEPTH)+1 bits.
- When dout_valid=0, dout and dout_bytes hold their last values (0 after reset).

Optional Feature:
- Macro: CIPHER_PACKER_BIG_ENDIAN_EN.
- Defined:
  - First byte of each word goes to [31:24], byte k to [31-8k:24-8k].
  - Partial words are left-aligned, with unused low bytes 0.
  - dout_bytes semantics are unchanged.
- Undefined: little-endian packing as described above.

Test Plan:
1. Reset, then bytes 0x11,0x22,0x33,0x44 on four consecutive cycles with dout_ready=1 -> dout=0x44332211, dout_bytes=4, dout_valid high for one cycle, the cycle after 0x44.
2. Bytes 0xAA,0xBB, then flush alone -> dout=0x0000BBAA, dout_bytes=2. A further flush with nothing pending -> no word.
3. Bytes 0x01,0x02,0x03 with flush asserted in the same cycle as 0x03 -> one word 0x00030201, dout_bytes=3.
4. dout_ready=0, stream 36 bytes with FIFO_DEPTH=8 -> almost_full rises when occupancy reaches 6. Eight words are held. Word 9 is dropped and overflow=1. Drain yields words 1..8 intact. clear_overflow returns overflow to 0.
5. FIFO full, dout_ready=1 and a word completing in the same cycle -> no drop, occupancy stays 8, overflow stays 0.
6. Assert rst_n=0 asynchronously after two bytes, with 3 words queued -> all outputs return to reset values immediately. Subsequent bytes 0x55,0x66,0x77,0x88 produce 0x88776655. With CIPHER_PACKER_BIG_ENDIAN_EN they produce 0x55667788.
